hamming_encoder_stream: RTL



---
 rtl/hamming_pkg.sv | 48 ++++
 rtl/hamming_parity_calc.sv | 41 ++++
 rtl/hamming_encoder_stream.sv | 98 +++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared sizing helpers for the streaming Hamming encoder.
// Defining HAMMING_SECDED_EN appends an even overall-parity bit to every codeword.
package hamming_pkg;

  localparam int WCNT_W = 16;
  localparam int NUM_LEGAL_DATA_W = 4;
  localparam int LEGAL_DATA_W [NUM_LEGAL_DATA_W] = '{4, 11, 26, 57};

`ifdef HAMMING_SECDED_EN
  localparam bit SECDED = 1'b1;
`else
  localparam bit SECDED = 1'b0;
`endif

  // Smallest r with 2^r >= data_w + r + 1; the descending scan leaves the smallest match.
  function automatic int par_w(input int data_w);
    par_w = 7;
    for (int r = 7; r >= 1; r--)
      if ((1 << r) >= data_w + r + 1) par_w = r;
  endfunction

  function automatic int code_w(input int data_w, input bit secded);
    return data_w + par_w(data_w) + (secded ? 1 : 0);
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic bit is_legal_data_w(input int data_w);
    is_legal_data_w = 1'b0;
    for (int i = 0; i < NUM_LEGAL_DATA_W; i++)
      if (LEGAL_DATA_W[i] == data_w) is_legal_data_w = 1'b1;
  endfunction

  // Data bit carried by non-power-of-two position pos: skip the parity slots at or below it.
  function automatic int data_idx(input int pos);
    return pos - 1 - $clog2(pos + 1);
  endfunction

  // Positions covered by the parity bit at 2^k, excluding that parity bit itself.
  function automatic logic [63:0] cover_mask(input int k);
    cover_mask = '0;
    for (int p = 1; p <= 64; p++)
      if (((p >> k) & 1) == 1 && p != (1 << k)) cover_mask[p-1] = 1'b1;
  endfunction

endpackage

// File: rtl/hamming_parity_calc.sv
// Combinational Hamming codeword builder: places data bits and computes parity.
// With HAMMING_SECDED_EN the top bit carries even parity over all other code bits.
module hamming_parity_calc
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0]                 data_i,
  output logic [code_w(DATA_W, SECDED)-1:0] code_o
);

  localparam int PAR_W = par_w(DATA_W);
  localparam int HAM_W = DATA_W + PAR_W;

  logic [HAM_W-1:0] placed;
  logic [HAM_W-1:0] ham;
  logic [PAR_W-1:0] par;

  // placed has zeros in the parity slots so the checks never depend on themselves.
  for (genvar p = 1; p <= HAM_W; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign placed[p-1] = 1'b0;
      assign ham[p-1]    = par[$clog2(p)];
    end else begin : g_dat
      assign placed[p-1] = data_i[data_idx(p)];
      assign ham[p-1]    = data_i[data_idx(p)];
    end
  end

  for (genvar k = 0; k < PAR_W; k++) begin : g_chk
    localparam logic [63:0] COVER = cover_mask(k);
    assign par[k] = ^(placed & COVER[HAM_W-1:0]);
  end

`ifdef HAMMING_SECDED_EN
  assign code_o = {^ham, ham};
`else
  assign code_o = ham;
`endif

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming encoder: one-deep output register with backpressure, one-shot
// error injection and a wrapping word counter. HAMMING_SECDED_EN selects SECDED codewords.
module hamming_encoder_stream
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        ena,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_W-1:0]                           data_in,
  output logic [code_w(DATA_W, SECDED)-1:0]           code_out,
  output logic                                        valid_out,
  input  logic                                        out_ready,
  input  logic                                        inj_arm,
  input  logic [$clog2(code_w(DATA_W, SECDED)+1)-1:0] inj_pos,
  output logic                                        inj_flag,
  output logic [WCNT_W-1:0]                           word_cnt
);

  localparam int CODE_W = code_w(DATA_W, SECDED);
  localparam int POS_W  = $clog2(CODE_W + 1);

  logic [CODE_W-1:0] enc;
  logic [CODE_W-1:0] flip;
  logic              accept;
  logic              pop;

  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              flag_q, flag_d;
  logic              armed_q, armed_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;

  hamming_parity_calc #(.DATA_W(DATA_W)) u_parity (
    .data_i (data_in),
    .code_o (enc)
  );

  assign in_ready = ena & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = ena & valid_q & out_ready & ~accept;

  // armed_q is only ever set with an in-range position, so the mask has at most one bit.
  for (genvar i = 0; i < CODE_W; i++) begin : g_flip
    assign flip[i] = armed_q & (pos_q == POS_W'(i + 1));
  end

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    flag_d  = flag_q;
    armed_d = armed_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    if (accept) begin
      code_d  = enc ^ flip;
      flag_d  = armed_q;
      valid_d = 1'b1;
      armed_d = 1'b0;
      cnt_d   = cnt_q + 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
    // A new arm lands after the current word has taken the previous arm state.
    if (ena & inj_arm) begin
      pos_d   = inj_pos;
      armed_d = (inj_pos != '0) && (inj_pos <= POS_W'(CODE_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      armed_q <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
      armed_q <= armed_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code_out  = code_q;
  assign valid_out = valid_q;
  assign inj_flag  = flag_q;
  assign word_cnt  = cnt_q;

endmodule
